// File: rtl/db9md_pkg.sv
//------------------------------------------------------------------------------
// db9md_pkg : shared types and bit-index constants for the DB9 Mega Drive scanner
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package db9md_pkg;

  typedef enum logic [1:0] {
    P1_SCAN = 2'd0,
    P1_IDLE = 2'd1,
    P2_SCAN = 2'd2,
    P2_IDLE = 2'd3
  } scan_state_e;

  // Output word bit positions
  localparam int C_BIT_R     = 0;
  localparam int C_BIT_L     = 1;
  localparam int C_BIT_D     = 2;
  localparam int C_BIT_U     = 3;
  localparam int C_BIT_B     = 4;
  localparam int C_BIT_C     = 5;
  localparam int C_BIT_A     = 6;
  localparam int C_BIT_START = 7;
  localparam int C_BIT_MODE  = 8;
  localparam int C_BIT_X     = 9;
  localparam int C_BIT_Y     = 10;
  localparam int C_BIT_Z     = 11;

  // joy_in line positions
  localparam int C_JOY_UP    = 0;
  localparam int C_JOY_DOWN  = 1;
  localparam int C_JOY_LEFT  = 2;
  localparam int C_JOY_RIGHT = 3;
  localparam int C_JOY_BA    = 4;
  localparam int C_JOY_CS    = 5;

endpackage

`default_nettype wire

// File: rtl/db9md_tick.sv
//------------------------------------------------------------------------------
// db9md_tick : free-running divider producing a one-cycle tick every CLK_DIV clocks
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module db9md_tick #(
  parameter int CLK_DIV = 400
) (
  input  logic clk_sys,
  input  logic reset_n,
  output logic o_tick
);

  logic [15:0] r_cnt;

  assign o_tick = (r_cnt == 16'(CLK_DIV - 1));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/db9md_pad_scanner.sv
//------------------------------------------------------------------------------
// db9md_pad_scanner : scans two Mega Drive / Atari pads through a DB9 splitter
// Revision          : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module db9md_pad_scanner
  import db9md_pkg::*;
#(
  parameter int CLK_DIV    = 400,
  parameter int IDLE_STEPS = 160
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [5:0]  joy_in,
  output logic        joy_mdsel,
  output logic        joy_split,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic [1:0]  pad_present,
  output logic [1:0]  six_btn
);

  logic        w_tick;
  logic [5:0]  r_sync1;
  logic [5:0]  r_sync2;
  logic [5:0]  w_data;
  scan_state_e r_state;
  scan_state_e w_state_nxt;
  logic [7:0]  r_step;
  logic [7:0]  w_step_nxt;
  logic        w_scan;
  logic        w_pad2;
  logic        w_sample;
  logic        w_commit;
  logic [11:0] r_shadow;
  logic        r_sh_present;
  logic        r_sh_six;
  logic [11:0] w_word;
  logic [15:0] r_joy1;
  logic [15:0] r_joy2;
  logic [1:0]  r_present;
  logic [1:0]  r_six;

  db9md_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= joy_in;
      r_sync2 <= r_sync1;
    end
  end

  // Lines are active-low; w_data is 1 for a pressed / pulled-low line
  assign w_data = ~r_sync2;

  assign w_scan    = (r_state == P1_SCAN) || (r_state == P2_SCAN);
  assign w_pad2    = (r_state == P2_SCAN) || (r_state == P2_IDLE);
  assign w_sample  = w_tick && w_scan;
  assign w_commit  = w_sample && (r_step == 8'd7);
  assign joy_mdsel = w_scan ? ~r_step[0] : 1'b1;
  assign joy_split = w_pad2;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= P1_SCAN;
      r_step  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    if (w_tick) begin
      if (w_scan ? (r_step == 8'd7) : (r_step == 8'(IDLE_STEPS - 1))) begin
        w_step_nxt = '0;
        case (r_state)
          P1_SCAN: w_state_nxt = P1_IDLE;
          P1_IDLE: w_state_nxt = P2_SCAN;
          P2_SCAN: w_state_nxt = P2_IDLE;
          default: w_state_nxt = P1_SCAN;
        endcase
      end else begin
        w_step_nxt = r_step + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow     <= '0;
      r_sh_present <= 1'b0;
      r_sh_six     <= 1'b0;
    end else if (w_sample) begin
      case (r_step)
        8'd0: begin
          r_shadow                   <= '0;
          r_shadow[C_BIT_R]          <= w_data[C_JOY_RIGHT];
          r_shadow[C_BIT_L]          <= w_data[C_JOY_LEFT];
          r_shadow[C_BIT_D]          <= w_data[C_JOY_DOWN];
          r_shadow[C_BIT_U]          <= w_data[C_JOY_UP];
          r_shadow[C_BIT_B]          <= w_data[C_JOY_BA];
          r_shadow[C_BIT_C]          <= w_data[C_JOY_CS];
          r_sh_present               <= 1'b0;
          r_sh_six                   <= 1'b0;
        end
        8'd1: begin
          r_shadow[C_BIT_A]          <= w_data[C_JOY_BA];
          r_shadow[C_BIT_START]      <= w_data[C_JOY_CS];
          r_sh_present               <= w_data[C_JOY_LEFT] & w_data[C_JOY_RIGHT];
        end
        8'd5: r_sh_six <= &w_data[C_JOY_RIGHT:C_JOY_UP];
        8'd6: begin
          if (r_sh_six) begin
            r_shadow[C_BIT_Z]        <= w_data[C_JOY_UP];
            r_shadow[C_BIT_Y]        <= w_data[C_JOY_DOWN];
            r_shadow[C_BIT_X]        <= w_data[C_JOY_LEFT];
            r_shadow[C_BIT_MODE]     <= w_data[C_JOY_RIGHT];
          end
        end
        default: ;
      endcase
    end
  end

  // A non-MD device only reports directions and B/C
  always_comb begin
    w_word = r_shadow;
    if (!r_sh_six) begin
      w_word[C_BIT_Z:C_BIT_MODE] = '0;
    end
    if (!r_sh_present) begin
      w_word[C_BIT_Z:C_BIT_A] = '0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_joy1    <= '0;
      r_joy2    <= '0;
      r_present <= '0;
      r_six     <= '0;
    end else if (w_commit) begin
      if (w_pad2) begin
        r_joy2       <= {4'b0000, w_word};
        r_present[1] <= r_sh_present;
        r_six[1]     <= r_sh_six & r_sh_present;
      end else begin
        r_joy1       <= {4'b0000, w_word};
        r_present[0] <= r_sh_present;
        r_six[0]     <= r_sh_six & r_sh_present;
      end
    end
  end

  assign joystick1   = r_joy1;
  assign joystick2   = r_joy2;
  assign pad_present = r_present;
  assign six_btn     = r_six;

endmodule

`default_nettype wire
